// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: PLL reset / lock qualification and staged per-domain reset release with retry and fault latch
module rst_seq_ctrl #(
   parameter int N_CH         = 2,
   parameter int PLL_RST_CYC  = 16,
   parameter int LOCK_TIMEOUT = 4096,
   parameter int LOCK_STABLE  = 64,
   parameter int STAGE_DLY    = 8,
   parameter int MAX_RETRY    = 3
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           pll_locked_i,
   input  logic                           sw_rst_i,
   output logic                           pll_areset_o,
   output logic [N_CH-1:0]                rst_n_o,
   output logic                           ready_o,
   output logic                           fault_o,
   output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt_o,
   output logic [2:0]                     state_o
);
   localparam int M0   = PLL_RST_CYC > LOCK_TIMEOUT ? PLL_RST_CYC : LOCK_TIMEOUT;
   localparam int M1   = LOCK_STABLE > STAGE_DLY ? LOCK_STABLE : STAGE_DLY;
   localparam int CMAX = M0 > M1 ? M0 : M1;
   localparam int CW   = $clog2(CMAX);
   localparam int HW   = N_CH > 1 ? $clog2(N_CH) : 1;
   localparam int RW   = $clog2(MAX_RETRY+1);
   localparam logic [CW-1:0] T_RST   = CW'(PLL_RST_CYC-1);
   localparam logic [CW-1:0] T_LOCK  = CW'(LOCK_TIMEOUT-1);
   localparam logic [CW-1:0] T_STAB  = CW'(LOCK_STABLE-1);
   localparam logic [CW-1:0] T_STG   = CW'(STAGE_DLY-1);
   localparam logic [HW-1:0] LAST_CH = HW'(N_CH-1);
   localparam logic [RW-1:0] R_MAX   = RW'(MAX_RETRY);

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5
   } state_t;

   state_t         state, state_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [HW-1:0]  ch, ch_n;
   logic [RW-1:0]  retry_n;
   logic [N_CH-1:0] rst_n_n;
   logic           sync1, lock_s;

   assign state_o = state;

   // two-flop synchroniser for the asynchronous PLL lock
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1  <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         sync1  <= pll_locked_i;
         lock_s <= sync1;
      end
   end

   // state, counters and outputs; outputs decode the next state so they are flop outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= PLL_RST;
         cnt          <= '0;
         ch           <= '0;
         retry_cnt_o  <= '0;
         rst_n_o      <= '0;
         pll_areset_o <= 1'b1;
         ready_o      <= 1'b0;
         fault_o      <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         ch           <= ch_n;
         retry_cnt_o  <= retry_n;
         rst_n_o      <= rst_n_n;
         pll_areset_o <= (state_n == PLL_RST) || (state_n == FAULT);
         ready_o      <= state_n == RUN;
         fault_o      <= state_n == FAULT;
      end
   end

   // next-state logic; lock loss outranks software reset in the released states
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ch_n    = ch;
      retry_n = retry_cnt_o;
      rst_n_n = rst_n_o;
      case (state)
         PLL_RST: begin
            rst_n_n = '0;
            cnt_n   = (cnt == T_RST) ? '0 : cnt + 1'b1;
            state_n = (cnt == T_RST) ? WAIT_LOCK : PLL_RST;
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_n = STABLE;
               cnt_n   = '0;
            end else if (cnt == T_LOCK) begin
               retry_n = retry_cnt_o + 1'b1;
               state_n = (retry_n == R_MAX) ? FAULT : PLL_RST;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STABLE: begin
            if (!lock_s) begin
               state_n = WAIT_LOCK;
               cnt_n   = '0;
            end else if (cnt == T_STAB) begin
               state_n = RELEASE;
               cnt_n   = '0;
               ch_n    = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RELEASE, RUN: begin
            if (!lock_s) begin
               state_n = PLL_RST;
               cnt_n   = '0;
               ch_n    = '0;
               rst_n_n = '0;
            end else if (sw_rst_i) begin
               state_n = RELEASE;
               cnt_n   = '0;
               ch_n    = '0;
               rst_n_n = '0;
            end else if (state == RELEASE) begin
               if (cnt == T_STG) begin
                  rst_n_n = rst_n_o | (N_CH'(1) << ch);
                  cnt_n   = '0;
                  ch_n    = (ch == LAST_CH) ? ch : ch + 1'b1;
                  state_n = (ch == LAST_CH) ? RUN : RELEASE;
                  retry_n = (ch == LAST_CH) ? '0 : retry_cnt_o;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         FAULT: begin
            rst_n_n = '0;
            if (sw_rst_i) begin
               state_n = PLL_RST;
               retry_n = '0;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = PLL_RST;
            cnt_n   = '0;
            ch_n    = '0;
            rst_n_n = '0;
         end
      endcase
   end
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: vector table, corner sequences and random stimulus against a timeline model
module tb_rst_seq_ctrl;
   localparam int NC = 2, PRC = 16, LT = 4096, LS = 64, SD = 8, MR = 3;

   logic          clk = 1'b0;
   logic          rst, lk, sw;
   logic          ar, rdy, flt;
   logic [NC-1:0] rstn;
   logic [1:0]    rtc;
   logic [2:0]    st;

   always #5 clk = ~clk;

   rst_seq_ctrl #(
      .N_CH(NC), .PLL_RST_CYC(PRC), .LOCK_TIMEOUT(LT),
      .LOCK_STABLE(LS), .STAGE_DLY(SD), .MAX_RETRY(MR)
   ) dut (
      .clk_i(clk), .rst_i(rst), .pll_locked_i(lk), .sw_rst_i(sw),
      .pll_areset_o(ar), .rst_n_o(rstn), .ready_o(rdy), .fault_o(flt),
      .retry_cnt_o(rtc), .state_o(st)
   );

   int errs = 0, checks = 0;
   bit mon = 1'b0;

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // timeline model: phase plus the edge index it was entered at; lock seen two edges late
   int k = 0, ent = 0, ph = 0, rtr = 0, nxt, e;
   bit ls, reent;
   bit hq[$];

   always @(posedge clk) begin
      k++;
      if (rst) begin
         ph = 0; ent = k; rtr = 0;
         hq.delete(); hq.push_back(1'b0); hq.push_back(1'b0);
      end else begin
         ls = hq.pop_front();
         hq.push_back(lk);
         e = k - ent;
         nxt = ph; reent = 1'b0;
         case (ph)
            0: if (e == PRC) nxt = 1;
            1: if (ls) nxt = 2;
               else if (e == LT) begin rtr++; nxt = (rtr == MR) ? 5 : 0; end
            2: if (!ls) nxt = 1; else if (e == LS) nxt = 3;
            3, 4: if (!ls) nxt = 0;
               else if (sw) begin nxt = 3; reent = 1'b1; end
               else if (ph == 3 && e / SD >= NC) begin nxt = 4; rtr = 0; end
            5: if (sw) begin nxt = 0; rtr = 0; end
            default: nxt = 0;
         endcase
         if (nxt != ph || reent) ent = k;
         ph = nxt;
      end
   end

   function automatic int exp_rstn();
      return ph == 4 ? (1 << NC) - 1 : ph == 3 ? (1 << ((k - ent) / SD)) - 1 : 0;
   endfunction

   always @(negedge clk) begin
      if (mon) begin
         chk("m_state", st, ph);
         chk("m_rst_n", rstn, exp_rstn());
         chk("m_areset", ar, ph == 0 || ph == 5);
         chk("m_ready", rdy, ph == 4);
         chk("m_fault", flt, ph == 5);
         chk("m_retry", rtc, rtr);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_state(input int s, input int lim, input string nm);
      int n = 0;
      while (int'(st) != s && n < lim) begin step(1); n++; end
      chk(nm, st, s);
   endtask

   task automatic wait_rstn(input int v, input int lim, input string nm);
      int n = 0;
      while (int'(rstn) != v && n < lim) begin step(1); n++; end
      chk(nm, rstn, v);
   endtask

   task automatic chk_all(input string p, input int s, input int rn, input int a, input int rd, input int f, input int rt);
      chk({p, "_state"}, st, s);
      chk({p, "_rst_n"}, rstn, rn);
      chk({p, "_areset"}, ar, a);
      chk({p, "_ready"}, rdy, rd);
      chk({p, "_fault"}, flt, f);
      chk({p, "_retry"}, rtc, rt);
   endtask

   typedef struct {
      bit r, l, s;
      int n;
      int st, rn, ar, rd, ft, rt;
   } vec_t;
   vec_t tbl[16];

   initial begin
      int cnt;
      tbl[0]  = '{1, 0, 0,  3, 0, 0, 1, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 15, 0, 0, 1, 0, 0, 0};
      tbl[2]  = '{0, 0, 0,  1, 1, 0, 0, 0, 0, 0};
      tbl[3]  = '{0, 1, 0,  2, 1, 0, 0, 0, 0, 0};
      tbl[4]  = '{0, 1, 0,  1, 2, 0, 0, 0, 0, 0};
      tbl[5]  = '{0, 1, 0, 63, 2, 0, 0, 0, 0, 0};
      tbl[6]  = '{0, 1, 0,  1, 3, 0, 0, 0, 0, 0};
      tbl[7]  = '{0, 1, 0,  7, 3, 0, 0, 0, 0, 0};
      tbl[8]  = '{0, 1, 0,  1, 3, 1, 0, 0, 0, 0};
      tbl[9]  = '{0, 1, 0,  7, 3, 1, 0, 0, 0, 0};
      tbl[10] = '{0, 1, 0,  1, 4, 3, 0, 1, 0, 0};
      tbl[11] = '{0, 1, 1,  1, 3, 0, 0, 0, 0, 0};
      tbl[12] = '{0, 1, 1,  3, 3, 0, 0, 0, 0, 0};
      tbl[13] = '{0, 1, 0,  7, 3, 0, 0, 0, 0, 0};
      tbl[14] = '{0, 1, 0,  1, 3, 1, 0, 0, 0, 0};
      tbl[15] = '{0, 1, 0,  8, 4, 3, 0, 1, 0, 0};
      rst = 1'b1; lk = 1'b0; sw = 1'b0;
      @(negedge clk);
      mon = 1'b1;
      for (int i = 0; i < 16; i++) begin
         rst = tbl[i].r; lk = tbl[i].l; sw = tbl[i].s;
         step(tbl[i].n);
         chk_all($sformatf("v%0d", i), tbl[i].st, tbl[i].rn, tbl[i].ar, tbl[i].rd, tbl[i].ft, tbl[i].rt);
      end
      // lock loss in RUN: all domains drop three edges after the input falls
      lk = 1'b0;
      step(2);
      chk_all("loss_n2", 4, 3, 0, 1, 0, 0);
      step(1);
      chk_all("loss_n3", 0, 0, 1, 0, 0, 0);
      lk = 1'b1;
      wait_state(4, 400, "relock_run");
      chk("relock_retry", rtc, 0);
      // one-cycle lock glitch in STABLE restarts the stability window
      rst = 1'b1; step(1); rst = 1'b0;
      wait_state(2, 100, "glitch_stable");
      step(30);
      lk = 1'b0; step(1); lk = 1'b1;
      wait_state(1, 10, "glitch_wait");
      chk("glitch_retry", rtc, 0);
      wait_state(2, 10, "glitch_restable");
      cnt = 0;
      while (rstn[0] == 1'b0 && cnt < 200) begin step(1); cnt++; end
      chk("stable_to_rel0", cnt, LS + SD);
      // lock loss and sw reset on the same edge in RELEASE
      lk = 1'b0; step(2);
      sw = 1'b1; step(1); sw = 1'b0;
      chk_all("simul", 0, 0, 1, 0, 0, 0);
      // synchronous reset mid-RELEASE
      lk = 1'b1;
      wait_rstn(1, 300, "rel_partial");
      rst = 1'b1; step(1); rst = 1'b0;
      chk_all("rst_mid", 0, 0, 1, 0, 0, 0);
      // never lock: three timeouts then FAULT, cleared by sw reset
      lk = 1'b0; rst = 1'b1; step(1); rst = 1'b0;
      step(3 * (PRC + LT) - 1);
      chk_all("pre_fault", 1, 0, 0, 0, 0, 2);
      step(1);
      chk_all("fault", 5, 0, 1, 0, 1, 3);
      step(40);
      chk_all("fault_hold", 5, 0, 1, 0, 1, 3);
      sw = 1'b1; step(1); sw = 1'b0;
      chk_all("fault_clr", 0, 0, 1, 0, 0, 0);
      // random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         rst = $urandom_range(0, 1999) == 0;
         sw  = $urandom_range(0, 149) == 0;
         lk  = lk ? ($urandom_range(0, 399) != 0) : ($urandom_range(0, 19) == 0);
         step(1);
      end
      rst = 1'b0; sw = 1'b0;
      step(1);
      mon = 1'b0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
